rca_accum_ctrl: RTL and testbench
=================================

// Module: rca_accum_ctrl
// PURPOSE
//  Frame accumulator wrapped around an external rca16bit instance.
//  Drives the adder's a/b ports (a = running total, b = incoming operand) and registers sum/cout back.
//  Sums a frame of N_OPS 16-bit operands arriving on a valid/ready stream.
//  Presents the frame total plus a sticky carry flag on a valid/ready output.
// PARAMETERS
//  N_OPS   4               operands per frame; legal range >= 1
//  CNT_W   $clog2(N_OPS)+1 operand counter width
// PORTS
//  clk         in   1   single clock; all state changes on rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   opens a frame; honoured only in IDLE
//  clr         in   1   synchronous abort: zero acc/cnt/ovf, go IDLE
//  in_valid    in   1   operand present
//  in_ready    out  1   block accepts operand this cycle
//  in_data     in   16  operand
//  adder_a     out  16  to rca16bit a: acc register
//  adder_b     out  16  to rca16bit b: in_data when in_ready, else 16'h0000
//  adder_sum   in   16  from rca16bit sum
//  adder_cout  in   1   from rca16bit cout
//  out_valid   out  1   frame result held
//  out_ready   in   1   consumer takes result
//  out_data    out  16  frame total (acc)
//  out_ovf     out  1   any carry-out during frame
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; acc=0, cnt=0, ovf=0.
//  - Reset outputs: in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
//  - Priority: reset > clr > normal operation. clr in any state behaves as reset, one cycle.
//  - FSM IDLE -> ACCUM on start (acc/cnt/ovf already 0). start is ignored in ACCUM and HOLD.
//  - ACCUM: in_ready=1. Accept = in_valid & in_ready.
//    - On accept: acc<=adder_sum; ovf<=ovf|adder_cout; cnt<=cnt+1.
//    - Accept with cnt==N_OPS-1: go HOLD.
//    - No accept: all state holds. Gaps in in_valid are legal.
//  - HOLD: in_ready=0; out_valid=1. out_data=acc and out_ovf=ovf, stable until handshake.
//    - On out_valid & out_ready: acc/cnt/ovf<=0, go IDLE.
//    - out_ready low: hold indefinitely.
//  - Latency: out_valid rises on the first cycle after the final operand's accept edge.
//  - Minimum frame = N_OPS+2 cycles (start, N_OPS accepts, HOLD).
//  - Adder path is purely combinational outside this block; the sum is sampled the same cycle as the accept.
//  - Arithmetic: modulo 2^16 wrap. ovf is sticky for the frame and does not feed back into acc.
//  - out_data/out_ovf always mirror acc/ovf. Consumers qualify them with out_valid.
//  - N_OPS=1: one accept moves ACCUM -> HOLD.
// CONFIGURATION
//  - ACC_SATURATE_EN defined:
//    - Accept with adder_cout=1 sets acc<=16'hFFFF.
//    - Once acc==16'hFFFF with ovf=1, further accepts keep acc at 16'hFFFF.
//    - ovf behaves as in the base mode.
//  - ACC_SATURATE_EN undefined: acc<=adder_sum always (wrap).
// TESTING
//  1. Basic frame: reset, start, ops 1,2,3,4 back-to-back.
//     -> out_valid the cycle after 4th accept; out_data=16'h000A, out_ovf=0.
//  2. Overflow: ops FFFF,0002,0000,0000.
//     -> wrap build: out_data=16'h0001, out_ovf=1.
//     -> ACC_SATURATE_EN build: out_data=16'hFFFF, out_ovf=1.
//  3. Backpressure: out_ready low 5 cycles in HOLD.
//     -> out_valid/out_data stable, in_ready=0; start ignored; IDLE one cycle after out_ready=1.
//  4. Input gaps: in_valid toggled 1,0,0,1,1,0,1 with ops 5,6,7,8.
//     -> only valid cycles accepted; out_data=16'h001A; adder_b=0 whenever in_ready=0.
//  5. Abort: clr after 2 accepts.
//     -> next cycle IDLE, busy=0, acc=0; a new frame of 1,1,1,1 yields 16'h0004.
//  6. Reset mid-frame: reset after 3 accepts, plus reset asserted while in HOLD.
//     -> every output returns to its reset value next edge; no stray out_valid.

Source files
------------

// File: rtl/rca_accum_ctrl_if.sv
// Stream, adder and control signals of the frame accumulator.
// The slave modport is the accumulator; master is the environment (producer, consumer, external adder).
interface rca_accum_ctrl_if;
    logic        start;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_sum;
    logic        adder_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        busy;

    modport master (
        output start, clr, in_valid, in_data, out_ready, adder_sum, adder_cout,
        input  in_ready, adder_a, adder_b, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  start, clr, in_valid, in_data, out_ready, adder_sum, adder_cout,
        output in_ready, adder_a, adder_b, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/rca_accum_ctrl.sv
// Frame accumulator around an external 16-bit ripple-carry adder: sums N_OPS operands per frame.
// Optional ACC_SATURATE_EN: clamp the running total at 16'hFFFF on carry-out instead of wrapping.
module rca_accum_ctrl #(
    parameter int N_OPS = 4,
    parameter int CNT_W = $clog2(N_OPS) + 1
) (
    input logic               clk,
    input logic               reset,
    rca_accum_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

    state_t            state_q, state_d;
    logic [15:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_s;
    logic              accept_s;
    logic [15:0]       acc_next_s;

    // Accept qualification derived from the registered state only
    always_comb begin
        in_ready_s = (state_q == ACCUM);
        accept_s   = in_ready_s & bus.in_valid;
    end

    // Value loaded into the accumulator on an accepted operand
    always_comb begin
`ifdef ACC_SATURATE_EN
        if (bus.adder_cout || ((acc_q == 16'hFFFF) && ovf_q)) begin
            acc_next_s = 16'hFFFF;
        end else begin
            acc_next_s = bus.adder_sum;
        end
`else
        acc_next_s = bus.adder_sum;
`endif
    end

    // Next-state logic: clr aborts from any state, otherwise the frame FSM
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            state_d = IDLE;
            acc_d   = 16'h0000;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_d = acc_next_s;
                        ovf_d = ovf_q | bus.adder_cout;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        acc_d   = 16'h0000;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = 16'h0000;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand is gated to zero so the adder sees no stray input outside ACCUM
    always_comb begin
        if (in_ready_s) begin
            bus.adder_b = bus.in_data;
        end else begin
            bus.adder_b = 16'h0000;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.adder_a   = acc_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rca_accum_ctrl.sv
// Directed bench for rca_accum_ctrl: expected frame results go into a scoreboard queue,
// a negedge monitor pops and compares on every output handshake.
module tb_rca_accum_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;

    rca_accum_ctrl_if bus();

    rca_accum_ctrl #(.N_OPS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the external rca16bit adder
    assign {bus.adder_cout, bus.adder_sum} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: compare each handshaken result against the scoreboard
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_out: out_data=%0h handshaken, nothing expected", bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(mon_e[15:0]));
                check("out_ovf", 32'(bus.out_ovf), 32'(mon_e[16]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                step();
                bus.in_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: operand %0h not accepted, in_ready=%0b", d, bus.in_ready);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'h0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'h0);
        check({tag, "_out_ovf"},   32'(bus.out_ovf),   32'h0);
        check({tag, "_busy"},      32'(bus.busy),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        t4_v[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] t4_d[7] = '{16'h0005, 16'hDEAD, 16'hDEAD, 16'h0006, 16'h0007, 16'hDEAD, 16'h0008};

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check_reset("rst");
        step();
        reset = 1'b0;

        // 1: basic frame
        exp_q.push_back({1'b0, 16'h000A});
        do_start();
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        send(16'h0004);
        @(negedge clk);
        check("t1_latency_out_valid", 32'(bus.out_valid), 32'h1);
        step();

        // 2: overflow
`ifdef ACC_SATURATE_EN
        exp_q.push_back({1'b1, 16'hFFFF});
`else
        exp_q.push_back({1'b1, 16'h0001});
`endif
        do_start();
        send(16'hFFFF);
        send(16'h0002);
        send(16'h0000);
        send(16'h0000);
        @(negedge clk);
        step();

        // 3: backpressure in HOLD, start ignored
        exp_q.push_back({1'b0, 16'h0064});
        do_start();
        send(16'd10);
        send(16'd20);
        send(16'd30);
        bus.out_ready = 1'b0;
        send(16'd40);
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_out_valid", 32'(bus.out_valid), 32'h1);
            check("t3_out_data",  32'(bus.out_data),  32'h64);
            check("t3_in_ready",  32'(bus.in_ready),  32'h0);
            step();
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("t3_idle_busy",      32'(bus.busy),      32'h0);
        check("t3_idle_out_valid", 32'(bus.out_valid), 32'h0);
        step();

        // 4: gaps in in_valid
        exp_q.push_back({1'b0, 16'h001A});
        do_start();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = t4_v[i];
            bus.in_data  = t4_d[i];
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hBEEF;
        @(negedge clk);
        check("t4_hold_out_valid", 32'(bus.out_valid), 32'h1);
        check("t4_hold_in_ready",  32'(bus.in_ready),  32'h0);
        check("t4_hold_adder_b",   32'(bus.adder_b),   32'h0);
        step();
        @(negedge clk);
        check("t4_idle_adder_b", 32'(bus.adder_b), 32'h0);
        step();

        // 5: abort after two accepts, then a fresh frame
        do_start();
        send(16'd100);
        send(16'd200);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        @(negedge clk);
        check("t5_busy",      32'(bus.busy),      32'h0);
        check("t5_out_data",  32'(bus.out_data),  32'h0);
        check("t5_out_valid", 32'(bus.out_valid), 32'h0);
        step();
        exp_q.push_back({1'b0, 16'h0004});
        do_start();
        for (int i = 0; i < 4; i++) send(16'h0001);
        @(negedge clk);
        step();

        // 6: reset mid-frame and in HOLD
        do_start();
        send(16'h0011);
        send(16'h0022);
        send(16'h0033);
        reset = 1'b1;
        step();
        @(negedge clk);
        check_reset("t6_mid");
        reset = 1'b0;
        step();
        do_start();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h0100);
        @(negedge clk);
        check("t6_hold_out_valid", 32'(bus.out_valid), 32'h1);
        reset = 1'b1;
        step();
        @(negedge clk);
        check_reset("t6_hold");
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("t6_no_stray_valid", 32'(bus.out_valid), 32'h0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
